regfile_mp: RTL and testbench

Parametrised multi-port integer register file, successor to the single-write-port core register file. It provides two combinational read ports and two synchronous write ports with fixed priority, plus optional write-to-read bypass. After reset it runs a self-clearing sweep that loads zero into every register, except the stack pointer (x2) and global pointer (x3), which get their ABI init values. It sits between decode (reads) and writeback/late-writeback (writes) in the RISC-V core.

---
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_mp.sv | 148 ++++++++++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus between the core pipeline and the multi-port register file.
//   master: decode/writeback side; drives read addresses and both write ports,
//           receives read data, busy and wdrop.
//   slave : register file; the reverse directions.
// Signals:
//   raddr0/raddr1  read addresses        rdata0/rdata1  combinational read data
//   we0/we1        write enables         waddr0/waddr1  write addresses
//   wdata0/wdata1  write data            busy           init sweep in progress
//   wdrop          a write was discarded while busy (one-cycle pulse)
interface regfile_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [AW-1:0]   raddr0;
  logic [AW-1:0]   raddr1;
  logic [XLEN-1:0] rdata0;
  logic [XLEN-1:0] rdata1;
  logic            we0;
  logic            we1;
  logic [AW-1:0]   waddr0;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata0;
  logic [XLEN-1:0] wdata1;
  logic            busy;
  logic            wdrop;

  modport master (
    output raddr0, raddr1, we0, we1, waddr0, waddr1, wdata0, wdata1,
    input  rdata0, rdata1, busy, wdrop
  );

  modport slave (
    input  raddr0, raddr1, we0, we1, waddr0, waddr1, wdata0, wdata1,
    output rdata0, rdata1, busy, wdrop
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two combinational read ports, two
// synchronous write ports (port 1 has priority) and optional write-to-read
// bypass. After reset a sweep loads every register with its init value
// (x2 = SP_INIT, x3 = GP_INIT, all others zero) before accepting accesses.
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous, active-low reset
//   bus    regfile_mp_if slave modport (read/write ports, busy, wdrop)
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter logic [31:0] SP_INIT = 32'h7fffeffc,
  parameter logic [31:0] GP_INIT = 32'h10008000,
  parameter bit          BYPASS  = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            wdrop_q, wdrop_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic            sweep_en;
  logic            run_en;
  logic [XLEN-1:0] init_val;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      wdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdrop_q <= wdrop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdrop_d = 1'b0;
    unique case (state_q)
      StInit: begin
        cnt_d   = cnt_q + AW'(1);
        wdrop_d = bus.we0 | bus.we1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    sweep_en = 1'b0;
    run_en   = 1'b0;
    unique case (state_q)
      StInit:  sweep_en = 1'b1;
      StRun:   run_en   = 1'b1;
      default: sweep_en = 1'b1;
    endcase
  end

  assign bus.busy  = sweep_en;
  assign bus.wdrop = wdrop_q;

  always_comb begin
    init_val = '0;
    if (cnt_q == AW'(2)) begin
      init_val = XLEN'(SP_INIT);
    end else if (cnt_q == AW'(3)) begin
      init_val = XLEN'(GP_INIT);
    end
  end

  // Storage next value; port 1 assigned last so it wins on an address clash.
  // Reset gates the sweep so a held reset leaves contents untouched.
  always_comb begin
    rf_d = rf_q;
    if (reset) begin
      if (sweep_en) begin
        rf_d[cnt_q] = init_val;
      end else if (run_en) begin
        if (bus.we0 && bus.waddr0 != '0) begin
          rf_d[bus.waddr0] = bus.wdata0;
        end
        if (bus.we1 && bus.waddr1 != '0) begin
          rf_d[bus.waddr1] = bus.wdata1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic            busy,
    input logic [AW-1:0]   raddr,
    input logic            we0,
    input logic [AW-1:0]   waddr0,
    input logic [XLEN-1:0] wdata0,
    input logic            we1,
    input logic [AW-1:0]   waddr1,
    input logic [XLEN-1:0] wdata1,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] res;
    if (busy || raddr == '0) begin
      res = '0;
    end else if (BYPASS && we1 && waddr1 == raddr) begin
      res = wdata1;
    end else if (BYPASS && we0 && waddr0 == raddr) begin
      res = wdata0;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  always_comb begin
    bus.rdata0 = read_port(sweep_en, bus.raddr0, bus.we0, bus.waddr0, bus.wdata0,
                           bus.we1, bus.waddr1, bus.wdata1, rf_q[bus.raddr0]);
    bus.rdata1 = read_port(sweep_en, bus.raddr1, bus.we0, bus.waddr0, bus.wdata0,
                           bus.we1, bus.waddr1, bus.wdata1, rf_q[bus.raddr1]);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (XLEN=32, NREGS=32, BYPASS=1).
module tb_regfile_mp;
  localparam logic [31:0] SpInit = 32'h7fffeffc;
  localparam logic [31:0] GpInit = 32'h10008000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32)) bus ();

  regfile_mp #(
    .XLEN    (32),
    .NREGS   (32),
    .SP_INIT (SpInit),
    .GP_INIT (GpInit),
    .BYPASS  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_init(input int r);
    if (r == 2) return SpInit;
    if (r == 3) return GpInit;
    return 32'h0;
  endfunction

  task automatic idle_bus();
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.waddr0 = '0; bus.waddr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  // Release reset and run a full sweep, checking busy at the edge boundary.
  task automatic full_sweep(input string tag);
    reset = 1'b1;
    repeat (31) tick();
    check_eq({tag, "_busy_31"}, 32'(bus.busy), 32'd1);
    tick();
    check_eq({tag, "_busy_32"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle_bus();
    bus.raddr0 = 5'd2;
    bus.raddr1 = 5'd3;
    repeat (3) tick();
    check_eq("rst_busy", 32'(bus.busy), 32'd1);
    check_eq("rst_wdrop", 32'(bus.wdrop), 32'd0);
    check_eq("rst_rdata0", bus.rdata0, 32'h0);
    check_eq("rst_rdata1", bus.rdata1, 32'h0);

    // Sweep with a write attempt after the 4th edge.
    reset = 1'b1;
    repeat (4) tick();
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h0000_ABCD;
    bus.raddr0 = 5'd9;
    #1;
    check_eq("busy_no_bypass", bus.rdata0, 32'h0);
    tick();
    check_eq("wdrop_set", 32'(bus.wdrop), 32'd1);
    idle_bus();
    tick();
    check_eq("wdrop_clear", 32'(bus.wdrop), 32'd0);
    repeat (25) tick();
    check_eq("sweep_busy_31", 32'(bus.busy), 32'd1);
    tick();
    check_eq("sweep_busy_32", 32'(bus.busy), 32'd0);

    for (int r = 0; r < 32; r++) begin
      bus.raddr0 = 5'(r);
      bus.raddr1 = 5'(31 - r);
      #1;
      check_eq($sformatf("init_rd0_x%0d", r), bus.rdata0, exp_init(r));
      check_eq($sformatf("init_rd1_x%0d", 31 - r), bus.rdata1, exp_init(31 - r));
    end

    // Single write with bypass.
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEAD_BEEF;
    bus.raddr0 = 5'd5; bus.raddr1 = 5'd6;
    #1;
    check_eq("bypass_p0", bus.rdata0, 32'hDEAD_BEEF);
    check_eq("bypass_other", bus.rdata1, 32'h0);
    tick();
    idle_bus();
    #1;
    check_eq("stored_x5", bus.rdata0, 32'hDEAD_BEEF);
    check_eq("run_wdrop", 32'(bus.wdrop), 32'd0);

    // Same address on both ports: port 1 wins.
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h0000_1111;
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h0000_2222;
    bus.raddr0 = 5'd7; bus.raddr1 = 5'd7;
    #1;
    check_eq("dual_bypass0", bus.rdata0, 32'h0000_2222);
    check_eq("dual_bypass1", bus.rdata1, 32'h0000_2222);
    tick();
    idle_bus();
    #1;
    check_eq("dual_stored", bus.rdata0, 32'h0000_2222);

    // Independent writes on both ports.
    bus.we0 = 1'b1; bus.waddr0 = 5'd8; bus.wdata0 = 32'h0808_0808;
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h0909_0909;
    bus.raddr0 = 5'd8; bus.raddr1 = 5'd9;
    #1;
    check_eq("split_bypass0", bus.rdata0, 32'h0808_0808);
    check_eq("split_bypass1", bus.rdata1, 32'h0909_0909);
    tick();
    idle_bus();
    #1;
    check_eq("split_stored0", bus.rdata0, 32'h0808_0808);
    check_eq("split_stored1", bus.rdata1, 32'h0909_0909);

    // x0 stays zero.
    bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF_FFFF;
    bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFF_FFFF;
    bus.raddr0 = 5'd0;
    #1;
    check_eq("x0_same", bus.rdata0, 32'h0);
    tick();
    idle_bus();
    #1;
    check_eq("x0_next", bus.rdata0, 32'h0);

    // Reset in RUN: busy rises on the next edge, not before.
    reset = 1'b0;
    #1;
    check_eq("run_rst_pre", 32'(bus.busy), 32'd0);
    tick();
    check_eq("run_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    repeat (10) tick();
    check_eq("mid_sweep_busy", 32'(bus.busy), 32'd1);
    // Reset pulse mid-sweep restarts the full sweep.
    reset = 1'b0;
    tick();
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd1);
    full_sweep("restart");

    bus.raddr0 = 5'd5; bus.raddr1 = 5'd2;
    #1;
    check_eq("x5_cleared", bus.rdata0, 32'h0);
    check_eq("x2_resweep", bus.rdata1, SpInit);
    bus.raddr0 = 5'd7; bus.raddr1 = 5'd3;
    #1;
    check_eq("x7_cleared", bus.rdata0, 32'h0);
    check_eq("x3_resweep", bus.rdata1, GpInit);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish by 100000");
    $fatal(1);
  end
endmodule
